// File: rtl/rv32_d_alu_decode_stage_pkg.sv
// Shared ALU control encodings and the decoded-entry payload for the RV32 decode stage.
package rv32_d_alu_decode_stage_pkg;

  localparam int unsigned ALU_CONTROL_WIDTH = 6;

  typedef logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD    = 6'd0;
  localparam alu_ctrl_t ALU_SUB    = 6'd1;
  localparam alu_ctrl_t ALU_SLL    = 6'd2;
  localparam alu_ctrl_t ALU_SLT    = 6'd3;
  localparam alu_ctrl_t ALU_SLTU   = 6'd4;
  localparam alu_ctrl_t ALU_XOR    = 6'd5;
  localparam alu_ctrl_t ALU_SRL    = 6'd6;
  localparam alu_ctrl_t ALU_SRA    = 6'd7;
  localparam alu_ctrl_t ALU_OR     = 6'd8;
  localparam alu_ctrl_t ALU_AND    = 6'd9;
  localparam alu_ctrl_t ALU_BEQ    = 6'd10;
  localparam alu_ctrl_t ALU_BNE    = 6'd11;
  localparam alu_ctrl_t ALU_BLT    = 6'd12;
  localparam alu_ctrl_t ALU_BGE    = 6'd13;
  localparam alu_ctrl_t ALU_BLTU   = 6'd14;
  localparam alu_ctrl_t ALU_BGEU   = 6'd15;
  localparam alu_ctrl_t ALU_MUL    = 6'd16;
  localparam alu_ctrl_t ALU_MULH   = 6'd17;
  localparam alu_ctrl_t ALU_MULHSU = 6'd18;
  localparam alu_ctrl_t ALU_MULHU  = 6'd19;
  localparam alu_ctrl_t ALU_DIV    = 6'd20;
  localparam alu_ctrl_t ALU_DIVU   = 6'd21;
  localparam alu_ctrl_t ALU_REM    = 6'd22;
  localparam alu_ctrl_t ALU_REMU   = 6'd23;
  localparam alu_ctrl_t ALU_SH1ADD = 6'd24;
  localparam alu_ctrl_t ALU_SH2ADD = 6'd25;
  localparam alu_ctrl_t ALU_SH3ADD = 6'd26;
  localparam alu_ctrl_t ALU_ANDN   = 6'd27;
  localparam alu_ctrl_t ALU_ORN    = 6'd28;
  localparam alu_ctrl_t ALU_XNOR   = 6'd29;
  localparam alu_ctrl_t ALU_CLZ    = 6'd30;
  localparam alu_ctrl_t ALU_CTZ    = 6'd31;
  localparam alu_ctrl_t ALU_CPOP   = 6'd32;
  localparam alu_ctrl_t ALU_MAX    = 6'd33;
  localparam alu_ctrl_t ALU_MAXU   = 6'd34;
  localparam alu_ctrl_t ALU_MIN    = 6'd35;
  localparam alu_ctrl_t ALU_MINU   = 6'd36;
  localparam alu_ctrl_t ALU_SEXTB  = 6'd37;
  localparam alu_ctrl_t ALU_SEXTH  = 6'd38;
  localparam alu_ctrl_t ALU_ZEXTH  = 6'd39;
  localparam alu_ctrl_t ALU_ROL    = 6'd40;
  localparam alu_ctrl_t ALU_ROR    = 6'd41;
  localparam alu_ctrl_t ALU_ORCB   = 6'd42;
  localparam alu_ctrl_t ALU_REV8   = 6'd43;
  localparam alu_ctrl_t ALU_CLMUL  = 6'd44;
  localparam alu_ctrl_t ALU_CLMULH = 6'd45;
  localparam alu_ctrl_t ALU_CLMULR = 6'd46;
  localparam alu_ctrl_t ALU_BCLR   = 6'd47;
  localparam alu_ctrl_t ALU_BSET   = 6'd48;
  localparam alu_ctrl_t ALU_BINV   = 6'd49;
  localparam alu_ctrl_t ALU_BEXT   = 6'd50;
  localparam alu_ctrl_t ALU_LUI    = 6'd51;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_ctrl_t control;
    logic      illegal;
    logic      mdu;
  } alu_dec_t;

endpackage

// File: rtl/rv32_d_alu_ctrl_lut.sv
// Combinational ALU control lookup for RV32I/M/B keyed by main-decoder op class.
module rv32_d_alu_ctrl_lut
  import rv32_d_alu_decode_stage_pkg::*;
#(
  parameter bit EN_M = 1'b1,
  parameter bit EN_B = 1'b1
) (
  input  logic [1:0]                   alu_op,
  input  logic [31:0]                  instr,
  output logic [ALU_CONTROL_WIDTH-1:0] control,
  output logic                         illegal,
  output logic                         mdu
);

  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rs2;
  logic [6:0] opc;
  logic       unused_bits;
  alu_ctrl_t  ctrl;
  logic       hit;
  logic       is_m;
  logic       is_b;

  assign f7  = instr[31:25];
  assign f3  = instr[14:12];
  assign rs2 = instr[24:20];
  assign opc = instr[6:0];
  assign unused_bits = ^{instr[19:15], instr[11:7]};

  always_comb begin
    ctrl = ALU_ADD;
    hit  = 1'b0;
    is_m = 1'b0;
    is_b = 1'b0;
    case (alu_op)
      2'b00: hit = 1'b1;
      2'b01: begin
        hit = 1'b1;
        case (f3)
          3'b000:  ctrl = ALU_BEQ;
          3'b001:  ctrl = ALU_BNE;
          3'b100:  ctrl = ALU_BLT;
          3'b101:  ctrl = ALU_BGE;
          3'b110:  ctrl = ALU_BLTU;
          3'b111:  ctrl = ALU_BGEU;
          default: hit = 1'b0;
        endcase
      end
      2'b10: begin
        if (opc == OPC_OP) begin
          hit  = 1'b1;
          is_m = (f7 == 7'b0000001);
          // Anything outside the base and M encodings belongs to the B extension.
          is_b = !is_m && (f7 != 7'b0000000) &&
                 !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
          case ({f7, f3})
            10'b0000000_000: ctrl = ALU_ADD;
            10'b0000000_001: ctrl = ALU_SLL;
            10'b0000000_010: ctrl = ALU_SLT;
            10'b0000000_011: ctrl = ALU_SLTU;
            10'b0000000_100: ctrl = ALU_XOR;
            10'b0000000_101: ctrl = ALU_SRL;
            10'b0000000_110: ctrl = ALU_OR;
            10'b0000000_111: ctrl = ALU_AND;
            10'b0100000_000: ctrl = ALU_SUB;
            10'b0100000_101: ctrl = ALU_SRA;
            10'b0100000_100: ctrl = ALU_XNOR;
            10'b0100000_110: ctrl = ALU_ORN;
            10'b0100000_111: ctrl = ALU_ANDN;
            10'b0000001_000: ctrl = ALU_MUL;
            10'b0000001_001: ctrl = ALU_MULH;
            10'b0000001_010: ctrl = ALU_MULHSU;
            10'b0000001_011: ctrl = ALU_MULHU;
            10'b0000001_100: ctrl = ALU_DIV;
            10'b0000001_101: ctrl = ALU_DIVU;
            10'b0000001_110: ctrl = ALU_REM;
            10'b0000001_111: ctrl = ALU_REMU;
            10'b0010000_010: ctrl = ALU_SH1ADD;
            10'b0010000_100: ctrl = ALU_SH2ADD;
            10'b0010000_110: ctrl = ALU_SH3ADD;
            10'b0000101_001: ctrl = ALU_CLMUL;
            10'b0000101_011: ctrl = ALU_CLMULH;
            10'b0000101_010: ctrl = ALU_CLMULR;
            10'b0000101_100: ctrl = ALU_MIN;
            10'b0000101_101: ctrl = ALU_MINU;
            10'b0000101_110: ctrl = ALU_MAX;
            10'b0000101_111: ctrl = ALU_MAXU;
            10'b0110000_001: ctrl = ALU_ROL;
            10'b0110000_101: ctrl = ALU_ROR;
            10'b0100100_001: ctrl = ALU_BCLR;
            10'b0100100_101: ctrl = ALU_BEXT;
            10'b0010100_001: ctrl = ALU_BSET;
            10'b0110100_001: ctrl = ALU_BINV;
            10'b0000100_100: begin ctrl = ALU_ZEXTH; hit = (rs2 == 5'd0); end
            default:         hit = 1'b0;
          endcase
        end else if (opc == OPC_OP_IMM) begin
          hit  = 1'b1;
          is_b = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                 ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
          casez ({f7, f3})
            10'b???????_000: ctrl = ALU_ADD;
            10'b???????_010: ctrl = ALU_SLT;
            10'b???????_011: ctrl = ALU_SLTU;
            10'b???????_100: ctrl = ALU_XOR;
            10'b???????_110: ctrl = ALU_OR;
            10'b???????_111: ctrl = ALU_AND;
            10'b0000000_001: ctrl = ALU_SLL;
            10'b0000000_101: ctrl = ALU_SRL;
            10'b0100000_101: ctrl = ALU_SRA;
            10'b0110000_101: ctrl = ALU_ROR;
            10'b0100100_001: ctrl = ALU_BCLR;
            10'b0100100_101: ctrl = ALU_BEXT;
            10'b0010100_001: ctrl = ALU_BSET;
            10'b0110100_001: ctrl = ALU_BINV;
            10'b0010100_101: begin ctrl = ALU_ORCB; hit = (rs2 == 5'b00111); end
            10'b0110100_101: begin ctrl = ALU_REV8; hit = (rs2 == 5'b11000); end
            10'b0110000_001: begin
              case (rs2)
                5'd0:    ctrl = ALU_CLZ;
                5'd1:    ctrl = ALU_CTZ;
                5'd2:    ctrl = ALU_CPOP;
                5'd4:    ctrl = ALU_SEXTB;
                5'd5:    ctrl = ALU_SEXTH;
                default: hit = 1'b0;
              endcase
            end
            default:         hit = 1'b0;
          endcase
        end
      end
      default: begin
        hit  = (opc == OPC_LUI) || (opc == OPC_AUIPC);
        ctrl = (opc == OPC_LUI) ? ALU_LUI : ALU_ADD;
      end
    endcase
  end

  // Unmatched or parameter-disabled encodings collapse to a safe ADD.
  always_comb begin
    illegal = !hit || (is_m && !EN_M) || (is_b && !EN_B);
    control = illegal ? ALU_ADD : ctrl;
    mdu     = !illegal && is_m && f3[2];
  end

endmodule

// File: rtl/rv32_d_alu_decode_stage.sv
// ALU control decode stage: combinational lookup at the input, 2-entry skid buffer at the output.
module rv32_d_alu_decode_stage
  import rv32_d_alu_decode_stage_pkg::*;
#(
  parameter bit          EN_M  = 1'b1,
  parameter bit          EN_B  = 1'b1,
  parameter int unsigned TAG_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [1:0]                   alu_op_i,
  input  logic [31:0]                  instr_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control_o,
  output logic                         illegal_o,
  output logic                         mdu_o,
  output logic [TAG_W-1:0]             tag_o
);

  alu_dec_t         dec;
  alu_dec_t         out_q, out_d, skid_q, skid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             valid_q, valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
  logic             in_fire, out_fire;

  rv32_d_alu_ctrl_lut #(
    .EN_M (EN_M),
    .EN_B (EN_B)
  ) u_lut (
    .alu_op  (alu_op_i),
    .instr   (instr_i),
    .control (dec.control),
    .illegal (dec.illegal),
    .mdu     (dec.mdu)
  );

  assign in_fire  = valid_i && ready_q;
  assign out_fire = valid_q && ready_i;

  // ready_q always mirrors an empty skid, so an input never arrives while the skid is occupied.
  always_comb begin
    out_d        = out_q;
    out_tag_d    = out_tag_q;
    skid_d       = skid_q;
    skid_tag_d   = skid_tag_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire || !valid_q) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_tag_d    = skid_tag_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d     = dec;
        out_tag_d = tag_i;
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_tag_d   = tag_i;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '{control: ALU_ADD, illegal: 1'b0, mdu: 1'b0};
      skid_q       <= '{control: ALU_ADD, illegal: 1'b0, mdu: 1'b0};
      out_tag_q    <= '0;
      skid_tag_q   <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_tag_q    <= out_tag_d;
      skid_tag_q   <= skid_tag_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign alu_control_o = out_q.control;
  assign illegal_o     = out_q.illegal;
  assign mdu_o         = out_q.mdu;
  assign tag_o         = out_tag_q;

endmodule

// File: tb/tb_rv32_d_alu_decode_stage.sv
// Directed bench for the ALU decode stage: decode table, skid-buffer handshake, flush and reset.
module tb_rv32_d_alu_decode_stage;

  localparam int unsigned TAG_W = 32;
  localparam int unsigned CW    = 6;

  localparam logic [CW-1:0] E_ADD = 6'd0;
  localparam logic [CW-1:0] E_SUB = 6'd1;
  localparam logic [CW-1:0] E_XOR = 6'd5;
  localparam logic [CW-1:0] E_BGE = 6'd13;
  localparam logic [CW-1:0] E_MUL = 6'd16;
  localparam logic [CW-1:0] E_DIV = 6'd20;
  localparam logic [CW-1:0] E_CLZ = 6'd30;
  localparam logic [CW-1:0] E_LUI = 6'd51;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_XOR  = 32'h003140B3;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_DIV  = 32'h0231C0B3;
  localparam logic [31:0] I_CLZ  = 32'h60011093;
  localparam logic [31:0] I_B010 = 32'h00002063;
  localparam logic [31:0] I_BGE  = 32'h00005063;
  localparam logic [31:0] I_LUI  = 32'h000010B7;

  logic             clk = 1'b0;
  logic             rst, flush, valid_in, ready_in;
  logic [1:0]       alu_op;
  logic [31:0]      instr;
  logic [TAG_W-1:0] tag_in;

  logic             a_ready, a_valid, a_illegal, a_mdu;
  logic [CW-1:0]    a_ctrl;
  logic [TAG_W-1:0] a_tag;
  logic             b_ready, b_valid, b_illegal, b_mdu;
  logic [CW-1:0]    b_ctrl;
  logic [TAG_W-1:0] b_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv32_d_alu_decode_stage #(.EN_M(1'b1), .EN_B(1'b1), .TAG_W(TAG_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(a_ready),
    .alu_op_i(alu_op), .instr_i(instr), .tag_i(tag_in), .valid_o(a_valid), .ready_i(ready_in),
    .alu_control_o(a_ctrl), .illegal_o(a_illegal), .mdu_o(a_mdu), .tag_o(a_tag)
  );

  rv32_d_alu_decode_stage #(.EN_M(1'b0), .EN_B(1'b0), .TAG_W(TAG_W)) u_dut_nomb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(b_ready),
    .alu_op_i(alu_op), .instr_i(instr), .tag_i(tag_in), .valid_o(b_valid), .ready_i(ready_in),
    .alu_control_o(b_ctrl), .illegal_o(b_illegal), .mdu_o(b_mdu), .tag_o(b_tag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] ins, input logic [TAG_W-1:0] t);
    valid_in = 1'b1;
    alu_op   = op;
    instr    = ins;
    tag_in   = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    alu_op = 2'b00; instr = 32'h0; tag_in = '0;
    step();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_ctrl", 32'(a_ctrl), 32'(E_ADD));
    chk("rst_illegal", 32'(a_illegal), 32'd0);
    chk("rst_mdu", 32'(a_mdu), 32'd0);
    chk("rst_tag", a_tag, 32'd0);
    rst = 1'b0; ready_in = 1'b1;

    drive(2'b10, I_ADD, 32'h11); step();
    chk("add_valid", 32'(a_valid), 32'd1);
    chk("add_ctrl", 32'(a_ctrl), 32'(E_ADD));
    chk("add_illegal", 32'(a_illegal), 32'd0);
    chk("add_mdu", 32'(a_mdu), 32'd0);
    chk("add_tag", a_tag, 32'h11);
    chk("add_nomb_illegal", 32'(b_illegal), 32'd0);

    drive(2'b10, I_MUL, 32'h12); step();
    chk("mul_ctrl", 32'(a_ctrl), 32'(E_MUL));
    chk("mul_mdu", 32'(a_mdu), 32'd0);
    chk("mul_nom_illegal", 32'(b_illegal), 32'd1);
    chk("mul_nom_ctrl", 32'(b_ctrl), 32'(E_ADD));

    drive(2'b10, I_DIV, 32'h13); step();
    chk("div_ctrl", 32'(a_ctrl), 32'(E_DIV));
    chk("div_mdu", 32'(a_mdu), 32'd1);
    chk("div_nom_mdu", 32'(b_mdu), 32'd0);
    chk("div_nom_illegal", 32'(b_illegal), 32'd1);

    drive(2'b10, I_CLZ, 32'h14); step();
    chk("clz_ctrl", 32'(a_ctrl), 32'(E_CLZ));
    chk("clz_illegal", 32'(a_illegal), 32'd0);
    chk("clz_nob_illegal", 32'(b_illegal), 32'd1);
    chk("clz_nob_ctrl", 32'(b_ctrl), 32'(E_ADD));

    drive(2'b01, I_B010, 32'h15); step();
    chk("br010_illegal", 32'(a_illegal), 32'd1);
    chk("br010_ctrl", 32'(a_ctrl), 32'(E_ADD));

    drive(2'b01, I_BGE, 32'h16); step();
    chk("bge_ctrl", 32'(a_ctrl), 32'(E_BGE));
    chk("bge_illegal", 32'(a_illegal), 32'd0);

    drive(2'b11, I_LUI, 32'h17); step();
    chk("lui_ctrl", 32'(a_ctrl), 32'(E_LUI));

    drive(2'b10, I_SUB, 32'h18); step();
    chk("sub_ctrl", 32'(a_ctrl), 32'(E_SUB));

    drive(2'b00, I_SUB, 32'h19); step();
    chk("op00_ctrl", 32'(a_ctrl), 32'(E_ADD));
    chk("op00_tag", a_tag, 32'h19);

    valid_in = 1'b0; step();
    chk("idle_valid", 32'(a_valid), 32'd0);
    chk("idle_hold_tag", a_tag, 32'h19);

    // Backpressure: two entries held, third presented but refused.
    ready_in = 1'b0;
    drive(2'b10, I_ADD, 32'hA1); step();
    chk("bp1_valid", 32'(a_valid), 32'd1);
    chk("bp1_tag", a_tag, 32'hA1);
    chk("bp1_ready", 32'(a_ready), 32'd1);
    drive(2'b10, I_SUB, 32'hA2); step();
    chk("bp2_tag", a_tag, 32'hA1);
    chk("bp2_ready", 32'(a_ready), 32'd0);
    drive(2'b10, I_XOR, 32'hA3); step();
    chk("bp3_tag", a_tag, 32'hA1);
    chk("bp3_ctrl", 32'(a_ctrl), 32'(E_ADD));
    chk("bp3_ready", 32'(a_ready), 32'd0);
    ready_in = 1'b1; step();
    chk("dr1_tag", a_tag, 32'hA2);
    chk("dr1_ctrl", 32'(a_ctrl), 32'(E_SUB));
    chk("dr1_ready", 32'(a_ready), 32'd1);
    step();
    chk("dr2_tag", a_tag, 32'hA3);
    chk("dr2_ctrl", 32'(a_ctrl), 32'(E_XOR));
    chk("dr2_valid", 32'(a_valid), 32'd1);
    valid_in = 1'b0; step();
    chk("dr3_valid", 32'(a_valid), 32'd0);

    // Flush with the skid full and a new input presented.
    ready_in = 1'b0;
    drive(2'b10, I_ADD, 32'hB1); step();
    drive(2'b10, I_SUB, 32'hB2); step();
    chk("fl_pre_ready", 32'(a_ready), 32'd0);
    flush = 1'b1;
    drive(2'b10, I_XOR, 32'hB3); step();
    chk("fl_valid", 32'(a_valid), 32'd0);
    chk("fl_ready", 32'(a_ready), 32'd1);
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1; step();
    chk("fl_dropped", 32'(a_valid), 32'd0);
    chk("fl_hold_tag", a_tag, 32'hB1);

    // Reset mid-stream, asserted together with flush.
    ready_in = 1'b0;
    drive(2'b10, I_DIV, 32'hC1); step();
    chk("pre_rst_mdu", 32'(a_mdu), 32'd1);
    drive(2'b10, I_MUL, 32'hC2); step();
    rst = 1'b1; flush = 1'b1;
    drive(2'b10, I_CLZ, 32'hC3); step();
    chk("mrst_valid", 32'(a_valid), 32'd0);
    chk("mrst_ready", 32'(a_ready), 32'd1);
    chk("mrst_ctrl", 32'(a_ctrl), 32'(E_ADD));
    chk("mrst_illegal", 32'(a_illegal), 32'd0);
    chk("mrst_mdu", 32'(a_mdu), 32'd0);
    chk("mrst_tag", a_tag, 32'd0);
    rst = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1; step();
    chk("post_rst_valid", 32'(a_valid), 32'd0);
    chk("post_rst_ready", 32'(a_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
